// File: rtl/sgdmac_rd_arbiter_if.sv
// sgdmac_rd_arbiter_if: bundle of the per-engine AR/R signals and the shared
// AXI3 read master AR/R channels used by sgdmac_rd_arbiter.
// Modport "master" is the arbiter's view; modport "slave" is the view of the
// surrounding system (engines plus downstream AXI slave).
interface sgdmac_rd_arbiter_if #(
  parameter int N_CH = 4
);
  // engine side
  logic [N_CH*32-1:0] s_araddr_i;
  logic [N_CH*4-1:0]  s_arlen_i;
  logic [N_CH-1:0]    s_arvalid_i;
  logic [N_CH-1:0]    s_arready_o;
  logic [N_CH-1:0]    s_rvalid_o;
  logic [N_CH-1:0]    s_rready_i;
  logic [31:0]        s_rdata_o;
  logic [1:0]         s_rresp_o;
  logic               s_rlast_o;
  // AXI3 read master side
  logic [3:0]         m_arid_o;
  logic [31:0]        m_araddr_o;
  logic [3:0]         m_arlen_o;
  logic [2:0]         m_arsize_o;
  logic [1:0]         m_arburst_o;
  logic               m_arvalid_o;
  logic               m_arready_i;
  logic [3:0]         m_rid_i;
  logic [31:0]        m_rdata_i;
  logic [1:0]         m_rresp_i;
  logic               m_rlast_i;
  logic               m_rvalid_i;
  logic               m_rready_o;

  modport master (
    input  s_araddr_i, s_arlen_i, s_arvalid_i, s_rready_i,
    input  m_arready_i, m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i,
    output s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o,
    output m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
    output m_arvalid_o, m_rready_o
  );

  modport slave (
    output s_araddr_i, s_arlen_i, s_arvalid_i, s_rready_i,
    output m_arready_i, m_rid_i, m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i,
    input  s_arready_o, s_rvalid_o, s_rdata_o, s_rresp_o, s_rlast_o,
    input  m_arid_o, m_araddr_o, m_arlen_o, m_arsize_o, m_arburst_o,
    input  m_arvalid_o, m_rready_o
  );
endinterface

// File: rtl/sgdmac_rd_arbiter.sv
// sgdmac_rd_arbiter: round-robin sharing of one AXI3 read master port between
// N_CH read engines. A granted AR is registered onto the master AR channel,
// tagged with the channel index in ARID; R beats are steered back by RID.
// Each channel is throttled once MAX_OUT bursts are outstanding.
// Optional feature macro: SGDMAC_RDARB_STATS_EN adds stat_bursts_o, a packed
// set of 16-bit per-channel granted-AR counters (wrapping).
module sgdmac_rd_arbiter #(
  parameter int N_CH    = 4,
  parameter int MAX_OUT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sgdmac_rd_arbiter_if.master   bus,
  output logic                  err_o
`ifdef SGDMAC_RDARB_STATS_EN
  ,
  output logic [N_CH*16-1:0]    stat_bursts_o
`endif
);

  localparam int CH_W = $clog2(N_CH);

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             last_grant_q, last_grant_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [3:0]             id_q, id_d;
  logic                   err_q, err_d;
  logic [N_CH-1:0][3:0]   out_cnt_q, out_cnt_d;

  logic [N_CH-1:0]        elig_s;
  logic                   found_s;
  logic [3:0]             win_s;
  logic [N_CH-1:0]        grant_oh_s;
  logic [N_CH-1:0]        s_rvalid_s;
  logic                   m_rready_s;
  logic                   rid_ok_s;
  logic [N_CH-1:0]        dec_s;
  logic                   under_s;

  // A channel may compete only while it requests and has burst credit left.
  always_comb begin
    elig_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      elig_s[k] = bus.s_arvalid_i[k] && (out_cnt_q[k] < 4'(MAX_OUT));
    end
  end

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int idx;
    found_s = 1'b0;
    win_s   = 4'd0;
    idx     = 0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = (int'(last_grant_q) + i) % N_CH;
      if (!found_s && elig_s[CH_W'(idx)]) begin
        found_s = 1'b1;
        win_s   = 4'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, AR capture and combinational grant strobe.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    id_d         = id_q;
    grant_oh_s   = '0;
    case (state_q)
      ST_ARB: begin
        if (found_s) begin
          for (int k = 0; k < N_CH; k++) begin
            if (win_s == 4'(k)) begin
              grant_oh_s[k] = 1'b1;
              addr_d        = bus.s_araddr_i[32*k +: 32];
              len_d         = bus.s_arlen_i[4*k +: 4];
            end else begin
              grant_oh_s[k] = 1'b0;
            end
          end
          id_d         = win_s;
          last_grant_d = win_s;
          state_d      = ST_ISSUE;
        end else begin
          state_d = ST_ARB;
        end
      end
      ST_ISSUE: begin
        if (bus.m_arready_i) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // R steering by RID; unknown IDs are accepted and dropped.
  always_comb begin
    s_rvalid_s = '0;
    m_rready_s = 1'b1;
    dec_s      = '0;
    rid_ok_s   = (int'(bus.m_rid_i) < N_CH);
    for (int k = 0; k < N_CH; k++) begin
      if (bus.m_rid_i == 4'(k)) begin
        s_rvalid_s[k] = bus.m_rvalid_i;
        m_rready_s    = bus.s_rready_i[k];
        dec_s[k]      = bus.m_rvalid_i && bus.s_rready_i[k] && bus.m_rlast_i;
      end else begin
        s_rvalid_s[k] = 1'b0;
      end
    end
  end

  // Outstanding-burst bookkeeping; simultaneous inc/dec cancel out.
  always_comb begin
    out_cnt_d = out_cnt_q;
    under_s   = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_oh_s[k] && !dec_s[k]) begin
        out_cnt_d[k] = out_cnt_q[k] + 4'd1;
      end else if (dec_s[k] && !grant_oh_s[k]) begin
        if (out_cnt_q[k] == 4'd0) begin
          under_s = 1'b1;
        end else begin
          out_cnt_d[k] = out_cnt_q[k] - 4'd1;
        end
      end else begin
        out_cnt_d[k] = out_cnt_q[k];
      end
    end
    err_d = err_q | under_s | (bus.m_rvalid_i && !rid_ok_s);
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_ARB;
      last_grant_q <= 4'(N_CH - 1);
      addr_q       <= 32'd0;
      len_q        <= 4'd0;
      id_q         <= 4'd0;
      err_q        <= 1'b0;
      out_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      id_q         <= id_d;
      err_q        <= err_d;
      out_cnt_q    <= out_cnt_d;
    end
  end

`ifdef SGDMAC_RDARB_STATS_EN
  logic [N_CH-1:0][15:0] stat_q, stat_d;

  // Per-channel granted-AR counters, wrapping at 16 bits.
  always_comb begin
    stat_d = stat_q;
    for (int k = 0; k < N_CH; k++) begin
      if (grant_oh_s[k]) begin
        stat_d[k] = stat_q[k] + 16'd1;
      end else begin
        stat_d[k] = stat_q[k];
      end
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_bursts_o = stat_q;
`endif

  assign bus.s_arready_o = grant_oh_s;
  assign bus.s_rvalid_o  = s_rvalid_s;
  assign bus.s_rdata_o   = bus.m_rdata_i;
  assign bus.s_rresp_o   = bus.m_rresp_i;
  assign bus.s_rlast_o   = bus.m_rlast_i;
  assign bus.m_rready_o  = m_rready_s;
  assign bus.m_arid_o    = id_q;
  assign bus.m_araddr_o  = addr_q;
  assign bus.m_arlen_o   = len_q;
  assign bus.m_arsize_o  = 3'b010;
  assign bus.m_arburst_o = 2'b01;
  assign bus.m_arvalid_o = (state_q == ST_ISSUE);
  assign err_o           = err_q;

endmodule

// File: tb/tb_sgdmac_rd_arbiter.sv
// Directed bench for sgdmac_rd_arbiter (N_CH=4, MAX_OUT=2). Expected master
// AR payloads are queued when a request is driven and checked when the
// master AR handshake happens.
module tb_sgdmac_rd_arbiter;
  localparam int N_CH    = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_o;
`ifdef SGDMAC_RDARB_STATS_EN
  logic [N_CH*16-1:0] stat_bursts_o;
`endif

  sgdmac_rd_arbiter_if #(.N_CH(N_CH)) bus ();

  sgdmac_rd_arbiter #(.N_CH(N_CH), .MAX_OUT(MAX_OUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err_o (err_o)
`ifdef SGDMAC_RDARB_STATS_EN
    ,
    .stat_bursts_o (stat_bursts_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  ar_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.s_araddr_i  = '0;
    bus.s_arlen_i   = '0;
    bus.s_arvalid_i = '0;
    bus.s_rready_i  = '0;
    bus.m_arready_i = 1'b0;
    bus.m_rid_i     = 4'd0;
    bus.m_rdata_i   = 32'd0;
    bus.m_rresp_i   = 2'b00;
    bus.m_rlast_i   = 1'b0;
    bus.m_rvalid_i  = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    chk("rst_arvalid", bus.m_arvalid_o, 1'b0);
    chk("rst_arready", bus.s_arready_o, 4'b0000);
    chk("rst_err", err_o, 1'b0);
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Drive a request on one channel and queue its expected master AR.
  task automatic post_req(input int ch, input logic [31:0] addr, input logic [3:0] len);
    ar_t e;
    bus.s_araddr_i[32*ch +: 32] = addr;
    bus.s_arlen_i[4*ch +: 4]    = len;
    bus.s_arvalid_i[ch]         = 1'b1;
    e.id   = 4'(ch);
    e.addr = addr;
    e.len  = len;
    exp_q.push_back(e);
  endtask

  // Check the grant strobe this cycle, then withdraw the request.
  task automatic take_grant(input int ch);
    logic [3:0] oh;
    oh = 4'b0001 << ch;
    @(negedge clk);
    chk("s_arready", bus.s_arready_o, oh);
    tick();
    bus.s_arvalid_i[ch] = 1'b0;
  endtask

  // Master AR phase: stall for the given cycles, then complete the handshake.
  task automatic finish_issue(input int stall);
    ar_t e;
    e = exp_q.pop_front();
    bus.m_arready_i = 1'b0;
    for (int c = 0; c < stall; c++) begin
      @(negedge clk);
      chk("stall_arvalid", bus.m_arvalid_o, 1'b1);
      chk("stall_addr", bus.m_araddr_o, e.addr);
      chk("stall_len", bus.m_arlen_o, e.len);
      chk("stall_id", bus.m_arid_o, e.id);
      chk("stall_noready", bus.s_arready_o, 4'b0000);
      tick();
    end
    bus.m_arready_i = 1'b1;
    @(negedge clk);
    chk("m_arvalid", bus.m_arvalid_o, 1'b1);
    chk("m_arid", bus.m_arid_o, e.id);
    chk("m_araddr", bus.m_araddr_o, e.addr);
    chk("m_arlen", bus.m_arlen_o, e.len);
    chk("m_arsize", bus.m_arsize_o, 3'b010);
    chk("m_arburst", bus.m_arburst_o, 2'b01);
    chk("issue_noready", bus.s_arready_o, 4'b0000);
    tick();
    bus.m_arready_i = 1'b0;
  endtask

  task automatic do_ar(input int ch, input logic [31:0] addr, input logic [3:0] len, input int stall);
    post_req(ch, addr, len);
    take_grant(ch);
    finish_issue(stall);
  endtask

  initial begin
    idle_inputs();
    do_reset();

    // All four channels request together: served 0,1,2,3, one every 2 cycles.
    for (int k = 0; k < N_CH; k++) begin
      post_req(k, 32'h0000_0100 * (k + 1), 4'(k + 3));
    end
    for (int k = 0; k < N_CH; k++) begin
      take_grant(k);
      finish_issue(0);
    end

    // Master back-pressure: payload held for 5 cycles.
    do_reset();
    do_ar(2, 32'h0000_1000, 4'd15, 5);

    // Throttle at MAX_OUT, release on RLAST for rid=1.
    do_reset();
    do_ar(1, 32'h0000_2000, 4'd1, 0);
    do_ar(1, 32'h0000_2040, 4'd1, 0);
    bus.s_araddr_i[32 +: 32] = 32'h0000_2080;
    bus.s_arlen_i[4 +: 4]    = 4'd2;
    bus.s_arvalid_i[1]       = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("throttled", bus.s_arready_o, 4'b0000);
      tick();
    end
    bus.m_rid_i    = 4'd1;
    bus.m_rvalid_i = 1'b1;
    bus.m_rlast_i  = 1'b1;
    bus.s_rready_i = 4'b0010;
    @(negedge clk);
    chk("rlast_cycle_noready", bus.s_arready_o, 4'b0000);
    chk("rlast_rready", bus.m_rready_o, 1'b1);
    chk("rlast_rvalid", bus.s_rvalid_o, 4'b0010);
    tick();
    bus.m_rvalid_i = 1'b0;
    bus.m_rlast_i  = 1'b0;
    bus.s_arvalid_i[1] = 1'b0;
    post_req(1, 32'h0000_2080, 4'd2);
    take_grant(1);
    finish_issue(0);

    // R back-pressure from engine 3.
    do_reset();
    bus.m_rid_i    = 4'd3;
    bus.m_rvalid_i = 1'b1;
    bus.m_rdata_i  = 32'hDEAD_BEEF;
    bus.m_rresp_i  = 2'b01;
    bus.s_rready_i = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("r3_rready_low", bus.m_rready_o, 1'b0);
      chk("r3_rvalid", bus.s_rvalid_o, 4'b1000);
      chk("r3_rdata", bus.s_rdata_o, 32'hDEAD_BEEF);
      chk("r3_rresp", bus.s_rresp_o, 2'b01);
      tick();
    end
    bus.s_rready_i = 4'b1000;
    @(negedge clk);
    chk("r3_rready_high", bus.m_rready_o, 1'b1);
    tick();
    idle_inputs();
    @(negedge clk);
    chk("r3_no_err", err_o, 1'b0);

    // Unknown RID is sunk and flags a sticky error.
    do_reset();
    bus.m_rid_i    = 4'd7;
    bus.m_rvalid_i = 1'b1;
    bus.m_rlast_i  = 1'b1;
    bus.s_rready_i = 4'b0000;
    @(negedge clk);
    chk("rid7_rready", bus.m_rready_o, 1'b1);
    chk("rid7_rvalid", bus.s_rvalid_o, 4'b0000);
    tick();
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rid7_err_sticky", err_o, 1'b1);
      tick();
    end
    do_reset();

    // RLAST with no outstanding burst flags an error.
    bus.m_rid_i    = 4'd2;
    bus.m_rvalid_i = 1'b1;
    bus.m_rlast_i  = 1'b1;
    bus.s_rready_i = 4'b0100;
    tick();
    idle_inputs();
    @(negedge clk);
    chk("underflow_err", err_o, 1'b1);

    // Grant and RLAST on ch0 in the same cycle leave its count at 1.
    do_reset();
    do_ar(0, 32'h0000_3000, 4'd0, 0);
    post_req(0, 32'h0000_3010, 4'd1);
    bus.m_rid_i    = 4'd0;
    bus.m_rvalid_i = 1'b1;
    bus.m_rlast_i  = 1'b1;
    bus.s_rready_i = 4'b0001;
    @(negedge clk);
    chk("same_cycle_grant", bus.s_arready_o, 4'b0001);
    chk("same_cycle_rready", bus.m_rready_o, 1'b1);
    tick();
    bus.s_arvalid_i[0] = 1'b0;
    bus.m_rvalid_i = 1'b0;
    bus.m_rlast_i  = 1'b0;
    finish_issue(0);
    do_ar(0, 32'h0000_3020, 4'd2, 0);
    bus.s_arvalid_i[0] = 1'b1;
    @(negedge clk);
    chk("cnt_reached_max", bus.s_arready_o, 4'b0000);
    chk("same_cycle_no_err", err_o, 1'b0);
    tick();
    bus.s_arvalid_i[0] = 1'b0;
`ifdef SGDMAC_RDARB_STATS_EN
    @(negedge clk);
    chk("stat_ch0", stat_bursts_o[15:0], 16'd3);
    chk("stat_ch1", stat_bursts_o[31:16], 16'd0);
`endif

    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
